// File: rtl/ir_pkg.sv
// Shared IR link definitions: transmitter state encoding and default timing,
// kept in one place so the receiver threshold always sits between the two space lengths.
package ir_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MARK,
        SPACE,
        GAP
    } state_t;

    localparam int DEF_MARK_CYC   = 1000;
    localparam int DEF_SPACE0_CYC = 4000;
    localparam int DEF_SPACE1_CYC = 11000;
    localparam int DEF_GAP_CYC    = 20000;

    // Midpoint threshold a gap-measuring receiver uses to tell a 1 from a 0.
    localparam int RX_THRESH_CYC  = (DEF_SPACE0_CYC + DEF_SPACE1_CYC) / 2;

    function automatic int maxOf3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ir_shift_tx_if.sv
// Word handshake plus IR line outputs of the pulse-distance transmitter.
interface ir_shift_tx_if #(
    parameter int N = 8
);
    logic         tx_valid;
    logic [N-1:0] tx_data;
    logic         tx_ready;
    logic         ir_env;
    logic         ir_out;
    logic         busy;
    logic         done;

    modport master (
        output tx_valid, tx_data,
        input  tx_ready, ir_env, ir_out, busy, done
    );

    modport slave (
        input  tx_valid, tx_data,
        output tx_ready, ir_env, ir_out, busy, done
    );
endinterface

// File: rtl/ir_carrier.sv
// Carrier generator for the IR LED: restarts high on every rising edge of the mark
// envelope and toggles every HALF cycles; HALF of 0 yields a constant-high carrier.
module ir_carrier #(
    parameter int HALF = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    output logic carrier
);
    localparam int HW = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [HW-1:0] LAST = HW'((HALF > 0) ? HALF - 1 : 0);

    logic          r_enD;
    logic          r_phase;
    logic [HW-1:0] r_cnt;
    logic          w_rise;
    logic          w_phase;
    logic [HW-1:0] w_cnt;

    // The first mark cycle must already show a high carrier, so the restart is
    // folded in combinationally instead of waiting one cycle for the registers.
    assign w_rise  = en & ~r_enD;
    assign w_phase = w_rise | r_phase;
    assign w_cnt   = w_rise ? '0 : r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_enD   <= 1'b0;
            r_phase <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_enD <= en;
            if (w_cnt == LAST) begin
                r_cnt   <= '0;
                r_phase <= ~w_phase;
            end else begin
                r_cnt   <= w_cnt + 1'b1;
                r_phase <= w_phase;
            end
        end
    end

    assign carrier = (HALF == 0) ? 1'b1 : w_phase;

endmodule

// File: rtl/ir_shift_tx.sv
// Pulse-distance IR transmitter: sends an N-bit word MSB-first as marks separated by
// short (0) or long (1) spaces, followed by an enforced idle gap.
module ir_shift_tx
    import ir_pkg::*;
#(
    parameter int N            = 8,
    parameter int MARK_CYC     = DEF_MARK_CYC,
    parameter int SPACE0_CYC   = DEF_SPACE0_CYC,
    parameter int SPACE1_CYC   = DEF_SPACE1_CYC,
    parameter int GAP_CYC      = DEF_GAP_CYC,
    parameter int CARRIER_HALF = 0
) (
    input  logic          clk,
    input  logic          reset_n,
    ir_shift_tx_if.slave  bus
);
    localparam int CNT_MAX = maxOf3(MARK_CYC, SPACE1_CYC, GAP_CYC);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int BIT_W   = $clog2(N + 1);

    localparam logic [CNT_W-1:0] MARK_LOAD   = CNT_W'(MARK_CYC - 1);
    localparam logic [CNT_W-1:0] SPACE0_LOAD = CNT_W'(SPACE0_CYC - 1);
    localparam logic [CNT_W-1:0] SPACE1_LOAD = CNT_W'(SPACE1_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'(GAP_CYC - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [BIT_W-1:0] r_bitCnt;
    logic [N-1:0]     r_shiftReg;
    logic             r_txReady;
    logic             r_env;
    logic             r_busy;
    logic             r_done;
    logic             w_carrier;

    // r_bitCnt counts the marks still to follow the current one; the start mark
    // begins at N, so the frame ends after N+1 marks and N spaces.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_bitCnt   <= '0;
            r_shiftReg <= '0;
            r_txReady  <= 1'b1;
            r_env      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.tx_valid && r_txReady) begin
                        r_shiftReg <= bus.tx_data;
                        r_bitCnt   <= BIT_W'(N);
                        r_cnt      <= MARK_LOAD;
                        r_state    <= MARK;
                        r_env      <= 1'b1;
                        r_busy     <= 1'b1;
                        r_txReady  <= 1'b0;
                    end
                end
                MARK: begin
                    if (r_cnt == '0) begin
                        r_env <= 1'b0;
                        if (r_bitCnt == '0) begin
                            r_done  <= 1'b1;
                            r_cnt   <= GAP_LOAD;
                            r_state <= GAP;
                        end else begin
                            r_cnt   <= r_shiftReg[N-1] ? SPACE1_LOAD : SPACE0_LOAD;
                            r_state <= SPACE;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                SPACE: begin
                    if (r_cnt == '0) begin
                        r_shiftReg <= r_shiftReg << 1;
                        r_bitCnt   <= r_bitCnt - 1'b1;
                        r_cnt      <= MARK_LOAD;
                        r_state    <= MARK;
                        r_env      <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                GAP: begin
                    if (r_cnt == '0) begin
                        r_state   <= IDLE;
                        r_busy    <= 1'b0;
                        r_txReady <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_env     <= 1'b0;
                    r_busy    <= 1'b0;
                    r_txReady <= 1'b1;
                end
            endcase
        end
    end

    ir_carrier #(
        .HALF (CARRIER_HALF)
    ) u_carrier (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (r_env),
        .carrier (w_carrier)
    );

    assign bus.tx_ready = r_txReady;
    assign bus.ir_env   = r_env;
    assign bus.ir_out   = r_env & w_carrier;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;

endmodule

// File: tb/tb_ir_shift_tx.sv
// Bench for ir_shift_tx: instance A is unmodulated with short timings, instance B uses
// a 1-cycle carrier half-period and 6-cycle marks; both are checked against a frame model.
module tb_ir_shift_tx;

    localparam int S0  = 3;
    localparam int S1  = 6;
    localparam int GAP = 4;

    typedef struct packed {
        logic env;
        logic drv;
        logic busy;
        logic done;
        logic rdy;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    int nTests = 0;
    int nFail  = 0;
    int cyc    = 0;
    int tAcc   = 0;

    bit         act  [2];
    logic [7:0] word [2];
    int         k    [2];

    int spA[$];
    int spB[$];
    int lowRunA = 0;
    int lowRunB = 0;

    ir_shift_tx_if #(.N(8)) ifA ();
    ir_shift_tx_if #(.N(8)) ifB ();

    ir_shift_tx #(
        .N(8), .MARK_CYC(2), .SPACE0_CYC(S0), .SPACE1_CYC(S1), .GAP_CYC(GAP), .CARRIER_HALF(0)
    ) dutA (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifA.slave)
    );

    ir_shift_tx #(
        .N(8), .MARK_CYC(6), .SPACE0_CYC(S0), .SPACE1_CYC(S1), .GAP_CYC(GAP), .CARRIER_HALF(1)
    ) dutB (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifB.slave)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nTests++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic failTimeout(input string name);
        nTests++;
        nFail++;
        $display("[TB] FAIL %s: wait expired at cycle %0d, expected event never came", name, cyc);
    endtask

    function automatic int markOf(input int i);
        return (i == 0) ? 2 : 6;
    endfunction

    function automatic int halfOf(input int i);
        return (i == 0) ? 0 : 1;
    endfunction

    function automatic int frameLen(input logic [7:0] w, input int mc);
        int len;
        len = 9 * mc + GAP;
        for (int i = 0; i < 8; i++) len += w[i] ? S1 : S0;
        return len;
    endfunction

    function automatic exp_t markExp(input int t, input int half);
        exp_t e;
        e = '{env: 1'b1, drv: 1'b1, busy: 1'b1, done: 1'b0, rdy: 1'b0};
        if (half != 0) e.drv = ((t / half) % 2) == 0;
        return e;
    endfunction

    // Expected outputs in the k-th cycle after acceptance (k starts at 1), found by
    // walking the frame: start mark, then space+mark per bit MSB first, then the gap.
    function automatic exp_t expAt(input logic [7:0] w, input int kk, input int mc, input int half);
        exp_t e;
        int t;
        int sp;
        e = '{env: 1'b0, drv: 1'b0, busy: 1'b1, done: 1'b0, rdy: 1'b0};
        t = kk - 1;
        if (t < mc) return markExp(t, half);
        t -= mc;
        for (int i = 7; i >= 0; i--) begin
            sp = w[i] ? S1 : S0;
            if (t < sp) return e;
            t -= sp;
            if (t < mc) return markExp(t, half);
            t -= mc;
        end
        e.done = (t == 0);
        return e;
    endfunction

    function automatic exp_t idleExp();
        return '{env: 1'b0, drv: 1'b0, busy: 1'b0, done: 1'b0, rdy: 1'b1};
    endfunction

    function automatic exp_t dutOut(input int i);
        if (i == 0)
            return '{env: ifA.ir_env, drv: ifA.ir_out, busy: ifA.busy, done: ifA.done, rdy: ifA.tx_ready};
        return '{env: ifB.ir_env, drv: ifB.ir_out, busy: ifB.busy, done: ifB.done, rdy: ifB.tx_ready};
    endfunction

    function automatic logic validOf(input int i);
        return (i == 0) ? ifA.tx_valid : ifB.tx_valid;
    endfunction

    function automatic logic [7:0] dataOf(input int i);
        return (i == 0) ? ifA.tx_data : ifB.tx_data;
    endfunction

    // Model: a word is taken only on an edge that ends an idle cycle with valid high.
    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
                act[i] = 1'b0;
            end else if (act[i]) begin
                k[i]++;
                if (k[i] > frameLen(word[i], markOf(i))) act[i] = 1'b0;
            end else if (validOf(i)) begin
                act[i]  = 1'b1;
                word[i] = dataOf(i);
                k[i]    = 1;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        exp_t d;
        string p;
        if (cyc > 0) begin
            for (int i = 0; i < 2; i++) begin
                e = (!reset_n || !act[i]) ? idleExp() : expAt(word[i], k[i], markOf(i), halfOf(i));
                d = dutOut(i);
                p = (i == 0) ? "A" : "B";
                checkOutput({p, "_ir_env"},   32'(d.env),  32'(e.env));
                checkOutput({p, "_ir_out"},   32'(d.drv),  32'(e.drv));
                checkOutput({p, "_busy"},     32'(d.busy), 32'(e.busy));
                checkOutput({p, "_done"},     32'(d.done), 32'(e.done));
                checkOutput({p, "_tx_ready"}, 32'(d.rdy),  32'(e.rdy));
            end
        end
    end

    // Space-length monitor on the DUT lines, independent of the model.
    always @(negedge clk) begin
        if (!ifA.busy) lowRunA = 0;
        else if (!ifA.ir_env) lowRunA++;
        else if (lowRunA > 0) begin spA.push_back(lowRunA); lowRunA = 0; end
        if (!ifB.busy) lowRunB = 0;
        else if (!ifB.ir_env) lowRunB++;
        else if (lowRunB > 0) begin spB.push_back(lowRunB); lowRunB = 0; end
    end

    task automatic applyStimulus(input int sel, input logic [7:0] w, input bit hold);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (((sel == 0) ? ifA.tx_ready : ifB.tx_ready) === 1'b1) ok = 1'b1;
        end
        if (!ok) begin
            failTimeout("accept");
            return;
        end
        tAcc = cyc;
        #1;
        if (sel == 0) begin ifA.tx_valid = 1'b1; ifA.tx_data = w; end
        else          begin ifB.tx_valid = 1'b1; ifB.tx_data = w; end
        @(posedge clk);
        #1;
        if (!hold) begin
            if (sel == 0) ifA.tx_valid = 1'b0;
            else          ifB.tx_valid = 1'b0;
        end
    endtask

    task automatic waitDone(input int sel, output int at);
        at = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (((sel == 0) ? ifA.done : ifB.done) === 1'b1) begin
                at = cyc;
                return;
            end
        end
        failTimeout("done");
    endtask

    task automatic waitReady(input int sel, output int at);
        at = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (((sel == 0) ? ifA.tx_ready : ifB.tx_ready) === 1'b1) begin
                at = cyc;
                return;
            end
        end
        failTimeout("ready");
    endtask

    task automatic checkSpaces(input string name, input int expSp[]);
        checkOutput({name, "_count"}, 32'(spA.size()), 32'(expSp.size()));
        for (int i = 0; i < expSp.size() && i < spA.size(); i++)
            checkOutput($sformatf("%s_space%0d", name, i), 32'(spA[i]), 32'(expSp[i]));
    endtask

    initial begin
        int tDone;
        int tRdy;
        logic [7:0] rx;
        logic [5:0] pat;
        bit found;

        ifA.tx_valid = 1'b0; ifA.tx_data = '0;
        ifB.tx_valid = 1'b0; ifB.tx_data = '0;

        // Model pinned against hand-computed numbers for 0xA5 with 2-cycle marks.
        checkOutput("model_len_A5", 32'(frameLen(8'hA5, 2)), 32'd58);
        checkOutput("model_done_A5", 32'(expAt(8'hA5, 55, 2, 0).done), 32'd1);

        repeat (3) @(negedge clk);
        checkOutput("rst_ir_env",   32'(ifA.ir_env),   32'd0);
        checkOutput("rst_ir_out",   32'(ifA.ir_out),   32'd0);
        checkOutput("rst_busy",     32'(ifA.busy),     32'd0);
        checkOutput("rst_done",     32'(ifA.done),     32'd0);
        checkOutput("rst_tx_ready", 32'(ifA.tx_ready), 32'd1);
        #1 reset_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("post_rst_tx_ready", 32'(ifA.tx_ready), 32'd1);
        checkOutput("post_rst_busy",     32'(ifA.busy),     32'd0);

        // 0xA5: start mark 2 + spaces 36 + eight marks 16 = 54 mark/space cycles, done next.
        spA.delete();
        applyStimulus(0, 8'hA5, 1'b0);
        waitDone(0, tDone);
        checkOutput("A5_done_latency", 32'(tDone - tAcc), 32'd55);
        waitReady(0, tRdy);
        checkOutput("A5_ready_after_done", 32'(tRdy - tDone), 32'd4);
        checkSpaces("A5", '{6, 3, 6, 3, 3, 6, 3, 6});

        // Back-to-back with valid held; data changes mid-frame only affect the next word.
        spA.delete();
        applyStimulus(0, 8'h00, 1'b1);
        repeat (5) @(negedge clk);
        #1 ifA.tx_data = 8'hFF;
        waitDone(0, tDone);
        waitReady(0, tRdy);
        checkOutput("b2b_gap", 32'(tRdy - tDone), 32'(GAP));
        @(posedge clk);
        #1 ifA.tx_valid = 1'b0;
        waitDone(0, tDone);
        waitReady(0, tRdy);
        checkSpaces("b2b", '{3, 3, 3, 3, 3, 3, 3, 3, 6, 6, 6, 6, 6, 6, 6, 6});

        // Toggling valid and data during a frame must be ignored.
        spA.delete();
        applyStimulus(0, 8'h5A, 1'b0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            ifA.tx_valid = i[0];
            ifA.tx_data  = 8'($urandom);
        end
        ifA.tx_valid = 1'b0;
        waitDone(0, tDone);
        waitReady(0, tRdy);
        checkSpaces("toggle", '{3, 6, 3, 6, 6, 3, 6, 3});

        // Reset during the 4th space of 0xA5 (cycles 24..26 after acceptance).
        applyStimulus(0, 8'hA5, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (act[0] && k[0] == 25) found = 1'b1;
        end
        if (!found) failTimeout("reach_space4");
        #2 reset_n = 1'b0;
        #1;
        checkOutput("midrst_ir_env",   32'(ifA.ir_env),   32'd0);
        checkOutput("midrst_ir_out",   32'(ifA.ir_out),   32'd0);
        checkOutput("midrst_busy",     32'(ifA.busy),     32'd0);
        checkOutput("midrst_done",     32'(ifA.done),     32'd0);
        checkOutput("midrst_tx_ready", 32'(ifA.tx_ready), 32'd1);
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
        spA.delete();
        applyStimulus(0, 8'h3C, 1'b0);
        waitDone(0, tDone);
        checkOutput("3C_done_latency", 32'(tDone - tAcc), 32'(18 + 3 + 3 + 6 + 6 + 6 + 6 + 3 + 3 + 1));
        waitReady(0, tRdy);
        checkSpaces("3C", '{3, 3, 6, 6, 6, 6, 3, 3});

        // Carrier instance: first mark reads 1,0,1,0,1,0; a threshold-5 receiver recovers 0x80.
        spB.delete();
        applyStimulus(1, 8'h80, 1'b0);
        pat = 6'b101010;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            checkOutput($sformatf("carrier_bit%0d", j), 32'(ifB.ir_out), 32'(pat[5 - j]));
        end
        waitDone(1, tDone);
        rx = '0;
        foreach (spB[i]) rx = {rx[6:0], (spB[i] > 5) ? 1'b1 : 1'b0};
        checkOutput("rx_space_count", 32'(spB.size()), 32'd8);
        checkOutput("rx_word", 32'(rx), 32'h80);
        waitReady(1, tRdy);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
